dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port shared data memory between NUM_REQ core data ports. Each port is the core's core_out_mem_* / core_in_mem_data_out bundle plus a valid/ready handshake.
- Picks one requester per transaction using round-robin order, drives the memory for one cycle, then returns read data or a write acknowledge to the winner.
- Sits at the top level between the cores and the shared memory, which has a synchronous read with 1-cycle latency.

Parameters:
- DATA_WIDTH, 32, data/address width.
- NUM_REQ, 2, number of requesting cores (>=2).
- ID_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester access request
- req_addr  in  NUM_REQ*DATA_WIDTH  packed byte addresses
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data
- req_we  in  NUM_REQ  write enable per requester
- req_mask  in  NUM_REQ*DATA_WIDTH/8  packed byte masks
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-hot response pulse
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters
- mem_addr  out  DATA_WIDTH  to memory
- mem_data_in  out  DATA_WIDTH  to memory
- mem_we  out  1  to memory
- mem_mask  out  DATA_WIDTH/8  to memory
- mem_data_out  in  DATA_WIDTH  from memory, valid the cycle after the address

Behaviour:
- Reset (asynchronous, any cycle): state=IDLE, rr_ptr=0, gnt_id=0, mem_addr/mem_data_in/mem_mask=0, mem_we=0. req_ready and rsp_valid are 0. Any in-flight transaction is dropped with no response.
- FSM states are IDLE, ACCESS and RESP.
- Arbitration, evaluated combinationally in IDLE and RESP:
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit wins. req_ready[winner]=1 for that cycle only.
  - On the clock edge: latch the winner's addr/data/we/mask into the mem_* registers, set gnt_id=winner, set rr_ptr=(winner+1) mod NUM_REQ, go to ACCESS.
  - If no request is valid: IDLE stays in IDLE, RESP goes to IDLE.
- ACCESS (one cycle):
  - mem_* outputs are valid and mem_we equals the latched we.
  - No req_ready is asserted. Next state is RESP.
- RESP (one cycle):
  - rsp_valid[gnt_id]=1 and rsp_data=mem_data_out.
  - For writes, rsp_valid is still pulsed as an acknowledge and rsp_data is don't-care.
  - mem_we=0 (registered cleared on the ACCESS->RESP edge).
  - Arbitration for the next transaction runs in this same cycle, so back-to-back transactions are allowed.
- Latency: request accepted in cycle N, memory access in N+1, response in N+2. Peak throughput is one transaction per 2 cycles.
- Handshake rules:
  - A requester holds req_valid and its payload stable until it sees req_ready.
  - The requester may deassert req_valid in the cycle after req_ready and waits for rsp_valid before issuing again.
  - The arbiter never asserts req_ready to a requester whose response is still outstanding. This holds structurally because only one transaction is in flight.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0. A requester waits at most NUM_REQ-1 other transactions.
- Simultaneous events:
  - req_valid arriving in ACCESS is ignored until RESP.
  - A requester may re-request in the same cycle its rsp_valid fires. It is arbitrated against the others with its priority already rotated to last.
- mem_we is never 1 outside ACCESS. mem_addr holds its last value when idle.
- Outputs req_ready and rsp_valid are always one-hot or zero.

Decomposition:
- Package dmem_arbiter_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the request payload struct (addr, data, we, mask), parameterised by DATA_WIDTH through the package's DATA_WIDTH constant.
- Sub-module rr_picker is combinational: inputs req vector and rr_ptr; outputs valid, winner index and one-hot. It is reusable for future arbiters.

Test Plan:
- Reset, then req_valid=01 with core0 read at addr 0x10, memory holding 0xDEADBEEF at 0x10 -> req_ready=01 in cycle 0, mem_addr=0x10 and mem_we=0 in cycle 1, rsp_valid=01 and rsp_data=0xDEADBEEF in cycle 2.
- Core1 write of 0xA5A5A5A5 to 0x20 with mask 0xF -> mem_we=1 for exactly one cycle with mem_data_in=0xA5A5A5A5, mask 0xF, then rsp_valid=10. A following read of 0x20 returns 0xA5A5A5A5.
- Both requesters held valid for 8 transactions -> req_ready sequence 01,10,01,10,…, one accept every 2 cycles, with each response going to the matching requester.
- Core0 alone requesting back-to-back -> accepted in every RESP cycle, giving rsp_valid at cycles 2,4,6.
- Both valid with rr_ptr=1 after reset (core1 granted first because only core0 was previously served) -> ordering honours rr_ptr.
- arst_n asserted during ACCESS of a write -> mem_we drops to 0 immediately and no rsp_valid is produced. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types for the data-memory arbiter
package dmem_arbiter_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  we;
        logic [MASK_WIDTH-1:0] mask;
    } req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester bundle plus shared-memory port of the arbiter
interface dmem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DW      = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DW-1:0]     req_addr;
    logic [NUM_REQ*DW-1:0]     req_data;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*DW/8-1:0]   req_mask;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DW-1:0]             rsp_data;
    logic [DW-1:0]             mem_addr;
    logic [DW-1:0]             mem_data_in;
    logic                      mem_we;
    logic [DW/8-1:0]           mem_mask;
    logic [DW-1:0]             mem_data_out;

    modport slave (
        input  req_valid, req_addr, req_data, req_we, req_mask, mem_data_out,
        output req_ready, rsp_valid, rsp_data, mem_addr, mem_data_in, mem_we, mem_mask
    );

    modport master (
        output req_valid, req_addr, req_data, req_we, req_mask, mem_data_out,
        input  req_ready, rsp_valid, rsp_data, mem_addr, mem_data_in, mem_we, mem_mask
    );
endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker, first set bit at or after ptr
module rr_picker #(
    parameter int N    = 2,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            valid_o,
    output logic [ID_W-1:0] idx_o,
    output logic [N-1:0]    onehot_o
);
    int cand;

    always_comb begin
        valid_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        cand     = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_i) + k) % N;
            if (!valid_o && req_i[cand]) begin
                valid_o        = 1'b1;
                idx_o          = ID_W'(cand);
                onehot_o[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one single-port data memory
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          arst_n,
    dmem_arbiter_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int MW = MASK_WIDTH;

    state_t            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_ptr_d;
    logic [ID_W-1:0]   gnt_id_q;
    req_t              mem_q;
    req_t              req_pl [NUM_REQ];

    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic [NUM_REQ-1:0] pick_oh;
    logic              arb_en;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_pl[i].addr = bus.req_addr[i*DW +: DW];
            req_pl[i].data = bus.req_data[i*DW +: DW];
            req_pl[i].we   = bus.req_we[i];
            req_pl[i].mask = bus.req_mask[i*MW +: MW];
        end
    end

    rr_picker #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req_i    (bus.req_valid),
        .ptr_i    (rr_ptr_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_id),
        .onehot_o (pick_oh)
    );

    // Arbitration also runs in RESP so a new transaction can start back-to-back.
    assign arb_en   = (state_q != ACCESS);
    assign rr_ptr_d = (int'(pick_id) == NUM_REQ - 1) ? '0 : pick_id + 1'b1;

    assign bus.req_ready   = arb_en ? pick_oh : '0;
    assign bus.rsp_valid   = (state_q == RESP) ? (NUM_REQ'(1) << gnt_id_q) : '0;
    assign bus.rsp_data    = bus.mem_data_out;
    assign bus.mem_addr    = mem_q.addr;
    assign bus.mem_data_in = mem_q.data;
    assign bus.mem_we      = mem_q.we;
    assign bus.mem_mask    = mem_q.mask;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_id_q <= '0;
            mem_q    <= '0;
        end else begin
            case (state_q)
                ACCESS: begin
                    mem_q.we <= 1'b0;
                    state_q  <= RESP;
                end
                default: begin
                    if (pick_valid) begin
                        mem_q    <= req_pl[pick_id];
                        gnt_id_q <= pick_id;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ACCESS;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with memory model and scoreboard
module tb_dmem_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.NUM_REQ(N), .DW(DW)) bus();

    dmem_arbiter #(.NUM_REQ(N)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Environment memory: synchronous read, byte-masked write.
    logic [31:0] env_mem [64];
    bit          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= 32'h0101_0101 * i;
            env_mem[4] <= 32'hDEAD_BEEF;
            loaded <= 1'b1;
        end else if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_mask[b]) env_mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_data_in[8*b +: 8];
        end
        bus.mem_data_out <= env_mem[bus.mem_addr[7:2]];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_we    = '0;
        bus.req_mask  = '0;
    endtask

    task automatic set_req(input int c, input bit we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        bus.req_addr[c*32 +: 32] = a;
        bus.req_data[c*32 +: 32] = d;
        bus.req_we[c]            = we;
        bus.req_mask[c*4 +: 4]   = m;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        clear_reqs();
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("rst_mem_addr",  64'(bus.mem_addr),  64'h0);
        chk("rst_mem_din",   64'(bus.mem_data_in), 64'h0);
        chk("rst_mem_we",    64'(bus.mem_we),    64'h0);
        chk("rst_mem_mask",  64'(bus.mem_mask),  64'h0);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    typedef struct {
        int          c;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic do_txn(input vec_t v);
        @(posedge clk); #1;
        set_req(v.c, v.we, v.addr, v.data, v.mask);
        bus.req_valid[v.c] = 1'b1;
        @(negedge clk);
        chk("txn_ready", 64'(bus.req_ready), 64'(1 << v.c));
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        chk("txn_acc_ready", 64'(bus.req_ready), 64'h0);
        chk("txn_mem_addr",  64'(bus.mem_addr),  64'(v.addr));
        chk("txn_mem_we",    64'(bus.mem_we),    64'(v.we));
        if (v.we) begin
            chk("txn_mem_din",  64'(bus.mem_data_in), 64'(v.data));
            chk("txn_mem_mask", 64'(bus.mem_mask),    64'(v.mask));
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("txn_rsp_valid", 64'(bus.rsp_valid), 64'(1 << v.c));
        chk("txn_resp_we",   64'(bus.mem_we),    64'h0);
        if (!v.we) chk("txn_rsp_data", 64'(bus.rsp_data), 64'(v.exp_rd));
        @(posedge clk); #1;
        @(negedge clk);
        chk("txn_idle_rsp", 64'(bus.rsp_valid), 64'h0);
    endtask

    // Scoreboard-driven phase: requesters issue randomly, the model predicts
    // grants by rotating priority and only allows an accept two cycles after the last.
    task automatic run_phase(input int ncyc, input bit [N-1:0] en, input int pct);
        logic [31:0] ref_mem [64];
        bit          pend  [N];
        bit          waitr [N];
        int          last_acc, last_win, c, w;
        logic [N-1:0] exp_ready;
        logic [31:0] a_addr, a_data, a_rd;
        logic [3:0]  a_mask;
        bit          a_we;
        do_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = env_mem[i];
        for (int i = 0; i < N; i++) begin pend[i] = 0; waitr[i] = 0; end
        last_acc = -10; last_win = N - 1;
        a_addr = 0; a_data = 0; a_rd = 0; a_mask = 0; a_we = 0; w = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (waitr[i] && bus.rsp_valid[i]) waitr[i] = 0;
                if (!waitr[i] && !pend[i] && en[i] && ($urandom % 100) < pct) begin
                    pend[i] = 1;
                    set_req(i, 1'($urandom), {24'h0, 4'($urandom), 2'b00}, $urandom, 4'($urandom));
                end
                bus.req_valid[i] = pend[i];
            end
            @(negedge clk);
            exp_ready = '0;
            c = -1;
            if (cyc - last_acc >= 2) begin
                for (int k = 1; k <= N; k++) begin
                    if (c < 0 && bus.req_valid[(last_win + k) % N]) c = (last_win + k) % N;
                end
                if (c >= 0) exp_ready[c] = 1'b1;
            end
            chk("rnd_ready", 64'(bus.req_ready), 64'(exp_ready));
            if (cyc == last_acc + 1) begin
                chk("rnd_mem_addr", 64'(bus.mem_addr), 64'(a_addr));
                chk("rnd_mem_we",   64'(bus.mem_we),   64'(a_we));
                if (a_we) begin
                    chk("rnd_mem_din",  64'(bus.mem_data_in), 64'(a_data));
                    chk("rnd_mem_mask", 64'(bus.mem_mask),    64'(a_mask));
                end
            end else begin
                chk("rnd_we_idle", 64'(bus.mem_we), 64'h0);
            end
            if (cyc == last_acc + 2) begin
                chk("rnd_rsp_valid", 64'(bus.rsp_valid), 64'(1 << w));
                if (!a_we) chk("rnd_rsp_data", 64'(bus.rsp_data), 64'(a_rd));
            end else begin
                chk("rnd_rsp_none", 64'(bus.rsp_valid), 64'h0);
            end
            if (c >= 0) begin
                last_acc = cyc; last_win = c; w = c;
                a_addr = bus.req_addr[c*32 +: 32];
                a_data = bus.req_data[c*32 +: 32];
                a_mask = bus.req_mask[c*4 +: 4];
                a_we   = bus.req_we[c];
                a_rd   = ref_mem[a_addr[7:2]];
                if (a_we)
                    for (int b = 0; b < 4; b++)
                        if (a_mask[b]) ref_mem[a_addr[7:2]][8*b +: 8] = a_data[8*b +: 8];
            end
            for (int i = 0; i < N; i++)
                if (bus.req_ready[i]) begin pend[i] = 0; waitr[i] = 1; end
        end
        @(posedge clk); #1;
        clear_reqs();
        repeat (3) @(posedge clk);
    endtask

    vec_t tbl [5];

    initial begin
        arst_n = 1'b0;
        clear_reqs();
        tbl[0] = '{c: 0, we: 0, addr: 32'h10, data: 32'h0,         mask: 4'h0, exp_rd: 32'hDEAD_BEEF};
        tbl[1] = '{c: 1, we: 1, addr: 32'h20, data: 32'hA5A5_A5A5, mask: 4'hF, exp_rd: 32'h0};
        tbl[2] = '{c: 0, we: 0, addr: 32'h20, data: 32'h0,         mask: 4'h0, exp_rd: 32'hA5A5_A5A5};
        tbl[3] = '{c: 1, we: 1, addr: 32'h20, data: 32'h1122_3344, mask: 4'h3, exp_rd: 32'h0};
        tbl[4] = '{c: 1, we: 0, addr: 32'h20, data: 32'h0,         mask: 4'h0, exp_rd: 32'hA5A5_3344};
        repeat (2) @(posedge clk);

        do_reset();
        for (int i = 0; i < 5; i++) do_txn(tbl[i]);

        // Pointer after serving core0 must favour core1 when both ask.
        do_reset();
        do_txn(tbl[0]);
        @(posedge clk); #1;
        set_req(0, 0, 32'h10, 0, 0);
        set_req(1, 0, 32'h14, 0, 0);
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("rr_first", 64'(bus.req_ready), 64'h2);
        @(posedge clk); #1;
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("rr_access_ready", 64'(bus.req_ready), 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rr_rsp1",    64'(bus.rsp_valid), 64'h2);
        chk("rr_second",  64'(bus.req_ready), 64'h1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (3) @(posedge clk);

        // Reset in the middle of a write access.
        do_reset();
        @(posedge clk); #1;
        set_req(1, 1, 32'h24, 32'h5555_AAAA, 4'hF);
        bus.req_valid = 2'b10;
        @(negedge clk);
        chk("ra_ready", 64'(bus.req_ready), 64'h2);
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        chk("ra_we_before", 64'(bus.mem_we), 64'h1);
        arst_n = 1'b0;
        #1;
        chk("ra_we_dropped", 64'(bus.mem_we), 64'h0);
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ra_no_rsp", 64'(bus.rsp_valid), 64'h0);
        end
        chk("ra_mem_kept", 64'(env_mem[9]), 64'h0909_0909);
        @(posedge clk); #1;
        set_req(0, 0, 32'h0, 0, 0);
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("ra_first_grant", 64'(bus.req_ready), 64'h1);
        @(posedge clk); #1;
        bus.req_valid = '0;

        run_phase(60,  2'b11, 100);
        run_phase(40,  2'b01, 100);
        run_phase(400, 2'b11, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
